arbitro_mux8x1: RTL and testbench



---
 rtl/arbitro_mux8x1.sv | 157 +++++++++++++++
 tb/tb_arbitro_mux8x1.sv | 136 +++++++++++++
 2 files changed

// File: rtl/arbitro_mux8x1.sv
// -----------------------------------------------------------------------------
// arbitro_mux8x1
// Round-robin arbiter and sequencer for the 8-to-1, 4-bit mux datapath.
// Eight requesters compete for the shared mux output. One of them owns it at a
// time. Ownership is bounded to MAX_RAFAGA accepted transfers, so no requester
// can starve the others.
//
// Parameters
//   MAX_RAFAGA : maximum accepted transfers per grant (1..15)
// Ports
//   CLK    in   single clock, rising edge
//   RESET  in   asynchronous, active-high reset
//   REQ    in   [7:0] per-requester request (REQ[i] -> mux input I[i] has data)
//   LISTO  in   consumer ready; a transfer happens when VALIDO && LISTO
//   S      out  [2:0] mux select (registered, equals current owner)
//   GNT    out  [7:0] one-hot grant (registered, zero when idle)
//   VALIDO out  mux output valid for the owner (registered)
// -----------------------------------------------------------------------------
module arbitro_mux8x1 #(
  parameter int unsigned MAX_RAFAGA = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] REQ,
  input  logic       LISTO,
  output logic [2:0] S,
  output logic [7:0] GNT,
  output logic       VALIDO
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Value of the counter on the transfer that completes a burst.
  localparam logic [3:0] LAST_CNT = 4'(MAX_RAFAGA - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] dueno_q, dueno_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [2:0] s_q,     s_d;
  logic [7:0] gnt_q,   gnt_d;
  logic       valido_q, valido_d;

  logic       any_req;
  logic       xfer;
  logic       rel;

  // Round-robin pick: first requester after 'last', wrapping. 'last' is
  // checked on the final step, so it ranks lowest and is only chosen
  // when it is the sole requester.
  function automatic logic [2:0] winner(input logic [2:0] last,
                                        input logic [7:0] req);
    logic [2:0] idx;
    logic       found;
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  endfunction

  assign any_req = |REQ;
  assign xfer    = (state_q == GRANT) && LISTO;
  // An owner that drops its request gives up the grant. A completed
  // burst also releases it.
  assign rel     = (state_q == GRANT) &&
                   (!REQ[dueno_q] || (xfer && (cnt_q == LAST_CNT)));

  // Next-state logic for the FSM, owner, priority pointer and burst counter.
  always_comb begin
    state_d = state_q;
    dueno_d = dueno_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          dueno_d = winner(ptr_q, REQ);
          cnt_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (rel) begin
          // Hand over at the same edge, with no idle bubble.
          // The new pointer is the releasing owner.
          ptr_d = dueno_q;
          cnt_d = 4'd0;
          if (any_req) begin
            state_d = GRANT;
            dueno_d = winner(dueno_q, REQ);
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        dueno_d = 3'd0;
        ptr_d   = 3'd7;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output next values are derived from the next state, so the outputs stay registered.
  always_comb begin
    if (state_d == GRANT) begin
      gnt_d    = 8'd1 << dueno_d;
      s_d      = dueno_d;
      valido_d = 1'b1;
    end else begin
      gnt_d    = 8'd0;
      s_d      = s_q;       // select holds while idle
      valido_d = 1'b0;
    end
  end

  // State and output registers; reset gives index 0 first priority (ptr = 7).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      dueno_q  <= 3'd0;
      ptr_q    <= 3'd7;
      cnt_q    <= 4'd0;
      s_q      <= 3'd0;
      gnt_q    <= 8'd0;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dueno_q  <= dueno_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      gnt_q    <= gnt_d;
      valido_q <= valido_d;
    end
  end

  assign S      = s_q;
  assign GNT    = gnt_q;
  assign VALIDO = valido_q;

endmodule

// File: tb/tb_arbitro_mux8x1.sv
// -----------------------------------------------------------------------------
// tb_arbitro_mux8x1
// Directed, table-driven bench for arbitro_mux8x1 (MAX_RAFAGA = 4).
// Inputs change on the falling edge. Outputs are compared on the next falling
// edge, which is half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_arbitro_mux8x1;

  logic       CLK;
  logic       RESET;
  logic [7:0] REQ;
  logic       LISTO;
  logic [2:0] S;
  logic [7:0] GNT;
  logic       VALIDO;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [7:0] req;
    logic       listo;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valido;
  } vec_t;

  vec_t vecs[$];

  arbitro_mux8x1 #(.MAX_RAFAGA(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (REQ),
    .LISTO (LISTO),
    .S     (S),
    .GNT   (GNT),
    .VALIDO(VALIDO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void add(input logic [7:0] req, input logic listo,
                              input logic [7:0] gnt, input logic [2:0] s,
                              input logic valido);
    vec_t v;
    v.req = req; v.listo = listo; v.gnt = gnt; v.s = s; v.valido = valido;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] g,
                       input logic [2:0] s, input logic v);
    n_vec++;
    if (GNT !== g || S !== s || VALIDO !== v) begin
      n_bad++;
      $display("FAIL %s: got GNT=%h S=%0d VALIDO=%b, want GNT=%h S=%0d VALIDO=%b",
               name, GNT, S, VALIDO, g, s, v);
    end
  endtask

  task automatic step(input logic [7:0] req, input logic listo,
                      input string name, input logic [7:0] g,
                      input logic [2:0] s, input logic v);
    REQ   = req;
    LISTO = listo;
    @(posedge CLK);
    @(negedge CLK);
    check(name, g, s, v);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Idle after reset
    add(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    // Single requester 0: granted one cycle later, re-granted after the burst
    for (int i = 0; i < 5; i++) add(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
    // Owner drops REQ with LISTO=1: go idle (ptr becomes 0)
    add(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    // All requesting: owners 1..7,0,1 each for exactly 4 cycles
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 4; j++) begin
        add(8'hFF, 1'b1, 8'd1 << ((1 + k) % 8), 3'((1 + k) % 8), 1'b1);
      end
    end
    // Everyone drops: go idle, S holds 1 (ptr becomes 1)
    add(8'h00, 1'b1, 8'h00, 3'd1, 1'b0);
    // REQ=81: winner after ptr 1 is 7; 7 does 2 transfers then drops
    for (int i = 0; i < 3; i++) add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1);
    add(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
    // 0 keeps the grant for 4 transfers even though 7 requests again
    for (int i = 0; i < 3; i++) add(8'h81, 1'b1, 8'h01, 3'd0, 1'b1);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1);
    // Owner 7: two transfers, then a 10-cycle LISTO stall, then the remaining two
    for (int i = 0; i < 2; i++)  add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1);
    for (int i = 0; i < 10; i++) add(8'h81, 1'b0, 8'h80, 3'd7, 1'b1);
    add(8'h81, 1'b1, 8'h80, 3'd7, 1'b1);
    add(8'h81, 1'b1, 8'h01, 3'd0, 1'b1);

    RESET = 1'b1;
    REQ   = 8'h00;
    LISTO = 1'b0;
    #1;
    check("reset", 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].listo, $sformatf("vec%0d", i),
           vecs[i].gnt, vecs[i].s, vecs[i].valido);
    end

    // Owner 0 drops; 5 takes over and reaches cnt=2
    step(8'h20, 1'b1, "to_owner5", 8'h20, 3'd5, 1'b1);
    step(8'h20, 1'b1, "owner5_c1", 8'h20, 3'd5, 1'b1);
    step(8'h20, 1'b1, "owner5_c2", 8'h20, 3'd5, 1'b1);
    // Reset pulse between edges clears the outputs without a clock
    RESET = 1'b1;
    #1;
    check("async_reset", 8'h00, 3'd0, 1'b0);
    #1;
    RESET = 1'b0;
    // Reset priority applies and the burst restarts from cnt=0
    step(8'h20, 1'b1, "post_reset", 8'h20, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'h21, 1'b1, $sformatf("post_reset_burst%0d", i), 8'h20, 3'd5, 1'b1);
    end
    step(8'h21, 1'b1, "post_reset_rotate", 8'h01, 3'd0, 1'b1);
    step(8'h00, 1'b1, "final_idle", 8'h00, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
